// File: rtl/fir_sequencer.sv
// Run controller for the FIR / moving-average datapath: button debounce, run FSM, result tracking.
// Define FIR_SEQ_AUTOSTOP_EN to stop automatically after SAMPLE_LIMIT shifts.
module fir_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SAMPLE_DIV      = 50000000,
    parameter int unsigned CALC_LAT        = 2,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned SAMPLE_LIMIT    = 1000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             toggleBtn,
    output logic             running,
    output logic             clear_taps,
    output logic             shift_en,
    output logic             result_valid,
    output logic [CNT_W-1:0] sample_count
);
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TM_W = $clog2(SAMPLE_DIV + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TM_W-1:0] TM_LAST = TM_W'(SAMPLE_DIV - 1);

    if (SAMPLE_DIV <= CALC_LAT + 1) begin : g_bad_div
        $error("fir_sequencer: SAMPLE_DIV must exceed CALC_LAT+1");
    end
    if (CALC_LAT < 1 || SAMPLE_LIMIT < 1) begin : g_bad_lat
        $error("fir_sequencer: CALC_LAT and SAMPLE_LIMIT must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;
    state_t state, state_nxt;

    logic                btn_m, btn_s, db, db_prev, press;
    logic [DB_W-1:0]     db_cnt;
    logic [TM_W-1:0]     timer;
    logic                timer_last, limit_hit, in_flight;
    logic [CALC_LAT-1:0] lat_line;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            btn_m   <= 1'b1;
            btn_s   <= 1'b1;
            db      <= 1'b1;
            db_prev <= 1'b1;
            db_cnt  <= '0;
        end else begin
            btn_m   <= toggleBtn;
            btn_s   <= btn_m;
            db_prev <= db;
            if (btn_s == db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db     <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_comb press = db_prev & ~db;
    always_comb timer_last = (timer == TM_LAST);

`ifdef FIR_SEQ_AUTOSTOP_EN
    localparam int unsigned SC_W = $clog2(SAMPLE_LIMIT + 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SAMPLE_LIMIT - 1);
    logic [SC_W-1:0] shift_cnt;

    always_ff @(posedge CLOCK_50) begin
        if (reset || state == CLEAR) shift_cnt <= '0;
        else if (shift_en)           shift_cnt <= shift_cnt + 1'b1;
    end
    // Derived from the timer rather than shift_en so it does not feed back through the FSM block.
    always_comb limit_hit = timer_last && (shift_cnt == SC_LAST);
`else
    always_comb limit_hit = 1'b0;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset || state != RUN) timer <= '0;
        else if (timer_last)       timer <= '0;
        else                       timer <= timer + 1'b1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            lat_line <= '0;
        end else begin
            lat_line[0] <= shift_en;
            for (int unsigned i = 1; i < CALC_LAT; i++) lat_line[i] <= lat_line[i-1];
        end
    end

    always_comb result_valid = lat_line[CALC_LAT-1];

    // A result still short of the output stage keeps DRAIN alive.
    always_comb begin
        in_flight = 1'b0;
        for (int unsigned i = 0; i + 1 < CALC_LAT; i++) in_flight = in_flight | lat_line[i];
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset || state == CLEAR) sample_count <= '0;
        else if (result_valid)       sample_count <= sample_count + 1'b1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        running    = 1'b0;
        clear_taps = 1'b0;
        shift_en   = 1'b0;
        case (state)
            IDLE: if (press) state_nxt = CLEAR;
            CLEAR: begin
                running    = 1'b1;
                clear_taps = 1'b1;
                state_nxt  = RUN;
            end
            RUN: begin
                running  = 1'b1;
                shift_en = timer_last;
                if (press || limit_hit) state_nxt = DRAIN;
            end
            DRAIN: begin
                running = 1'b1;
                if (!in_flight) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fir_sequencer.sv
// Bench for fir_sequencer: cycle-by-cycle comparison against an event-schedule model.
module tb_fir_sequencer;
    localparam int D = 4, SD = 8, LAT = 2, CW = 4;
    localparam int INF = 1 << 30;
`ifdef FIR_SEQ_AUTOSTOP_EN
    localparam int LIMIT = 5;
`else
    localparam int LIMIT = INF;
`endif

    logic CLOCK_50 = 1'b0, reset = 1'b1, toggleBtn = 1'b1;
    logic running, clear_taps, shift_en, result_valid;
    logic [CW-1:0] sample_count;
    logic [CW-1:0] held = '0;
    int cyc = 0;
    int n_cmp = 0, n_bad = 0;

    fir_sequencer #(.DEBOUNCE_CYCLES(D), .SAMPLE_DIV(SD), .CALC_LAT(LAT), .CNT_W(CW),
                    .SAMPLE_LIMIT(5)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .toggleBtn(toggleBtn), .running(running),
        .clear_taps(clear_taps), .shift_en(shift_en), .result_valid(result_valid),
        .sample_count(sample_count));

    always #10 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic test_reset();
        reset = 1'b1; toggleBtn = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        #1 reset = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge CLOCK_50);
            n_cmp++;
            if ({running, clear_taps, shift_en, result_valid} !== 4'b0000 || sample_count !== '0) begin
                n_bad++;
                $display("FAIL reset_idle cyc=%0d got run/clr/sh/rv=%b%b%b%b cnt=%0d want 0000 cnt=0",
                         cyc, running, clear_taps, shift_en, result_valid, sample_count);
            end
        end
        held = '0;
    endtask

    task automatic test_glitch();
        @(posedge CLOCK_50); #1 toggleBtn = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #1 toggleBtn = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge CLOCK_50);
            n_cmp++;
            if ({running, clear_taps, shift_en, result_valid} !== 4'b0000 || sample_count !== held) begin
                n_bad++;
                $display("FAIL glitch_ignored cyc=%0d got run/clr/sh/rv=%b%b%b%b cnt=%0d want 0000 cnt=%0d",
                         cyc, running, clear_taps, shift_en, result_valid, sample_count, held);
            end
        end
    endtask

    // Start press now; optional stop press taking effect stop_off cycles after CLEAR,
    // optional reset asserted reset_off cycles after CLEAR. Expected outputs come from
    // a precomputed schedule of shift cycles.
    task automatic run_session(input string name, input int stop_off, input int reset_off);
        int k, c, ps, r, stop_c, last_sh, run_end, end_c, ncnt;
        int shifts[$];
        logic e_run, e_clr, e_sh, e_rv;
        logic [CW-1:0] e_cnt;
        @(posedge CLOCK_50); #1;
        k  = cyc;
        c  = k + D + 3;
        ps = (stop_off >= 0) ? c + stop_off : INF;
        r  = (reset_off >= 0) ? c + reset_off : INF;
        stop_c = ps;
        for (int j = 1; c + SD*j <= ps && j <= LIMIT && c + SD*j <= r; j++) begin
            shifts.push_back(c + SD*j);
            if (j == LIMIT && c + SD*j < stop_c) stop_c = c + SD*j;
        end
        last_sh = (shifts.size() > 0) ? shifts[$] : c;
        run_end = (stop_c + 1 > last_sh + LAT) ? stop_c + 1 : last_sh + LAT;
        if (r < INF)       end_c = r + 12;
        else if (ps < INF) end_c = ((run_end > ps + 10) ? run_end : ps + 10) + 4;
        else               end_c = run_end + 4;
        e_cnt = held;
        for (int n = k; n <= end_c; n++) begin
            toggleBtn = !((n < k + 8) || (ps < INF && n >= ps - D - 2 && n < ps - D + 6));
            reset = (n == r);
            @(negedge CLOCK_50);
            e_sh = 1'b0; e_rv = 1'b0; ncnt = 0;
            foreach (shifts[i]) begin
                if (shifts[i] == n) e_sh = 1'b1;
                if (shifts[i] + LAT == n) e_rv = 1'b1;
                if (shifts[i] + LAT < n) ncnt++;
            end
            if (n > r) begin
                e_run = 1'b0; e_clr = 1'b0; e_sh = 1'b0; e_rv = 1'b0; e_cnt = '0;
            end else begin
                e_run = (n >= c && n <= run_end);
                e_clr = (n == c);
                e_cnt = (n <= c) ? held : ncnt[CW-1:0];
            end
            n_cmp++;
            if (running !== e_run) begin
                n_bad++; $display("FAIL %s running cyc=%0d got %b want %b", name, n - c, running, e_run);
            end
            n_cmp++;
            if (clear_taps !== e_clr) begin
                n_bad++; $display("FAIL %s clear_taps cyc=%0d got %b want %b", name, n - c, clear_taps, e_clr);
            end
            n_cmp++;
            if (shift_en !== e_sh) begin
                n_bad++; $display("FAIL %s shift_en cyc=%0d got %b want %b", name, n - c, shift_en, e_sh);
            end
            n_cmp++;
            if (result_valid !== e_rv) begin
                n_bad++; $display("FAIL %s result_valid cyc=%0d got %b want %b", name, n - c, result_valid, e_rv);
            end
            n_cmp++;
            if (sample_count !== e_cnt) begin
                n_bad++; $display("FAIL %s sample_count cyc=%0d got %0d want %0d", name, n - c, sample_count, e_cnt);
            end
            @(posedge CLOCK_50); #1;
        end
        toggleBtn = 1'b1;
        reset = 1'b0;
        held = e_cnt;
    endtask

    task automatic test_stop_mid();
        run_session("stop_mid", 24 + 2 + 1 + $urandom_range(0, 4), -1);
    endtask

    task automatic test_stop_on_shift();
        run_session("stop_on_shift", 32, -1);
    endtask

    task automatic test_wrap_reset();
        run_session("wrap_reset", -1, 8*17 + 2 + 2 + $urandom_range(0, 3));
    endtask

`ifdef FIR_SEQ_AUTOSTOP_EN
    task automatic test_autostop();
        run_session("autostop", -1, -1);
    endtask
`endif

    initial begin
        test_reset();
        test_glitch();
        test_stop_mid();
        test_stop_on_shift();
        test_wrap_reset();
`ifdef FIR_SEQ_AUTOSTOP_EN
        test_autostop();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fir_sequencer.md
Name: fir_sequencer

Overview:
Run controller for the FIR / moving-average datapath (LFSR source, X1..X3 tap shift register, averager).
- Turns the raw active-low toggle button into debounced start/stop commands.
- Sequences each start: clear taps, paced shift pulses, result-valid tracking, orderly drain on stop.
- Keeps a count of completed samples for the HEX display logic.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a button level change (20 ms at 50 MHz).
- SAMPLE_DIV, 50000000: cycles between consecutive shift_en pulses; must be > CALC_LAT+1.
- CALC_LAT, 2: cycles from shift_en to the datapath result being valid; must be >= 1.
- CNT_W, 16: width of sample_count.
- SAMPLE_LIMIT, 1000: auto-stop sample count; used only with FIR_SEQ_AUTOSTOP_EN.

Ports:
- CLOCK_50  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- toggleBtn  input  1  raw push button, active-low, asynchronous to CLOCK_50.
- running  output  1  high in CLEAR, RUN and DRAIN.
- clear_taps  output  1  one-cycle pulse; datapath zeroes X1..X3 and reseeds the LFSR.
- shift_en  output  1  one-cycle pulse; datapath shifts taps and draws a new sample.
- result_valid  output  1  one-cycle pulse; averager output Z is valid this cycle.
- sample_count  output  CNT_W  completed samples since the last start; wraps at 2^CNT_W.

Behaviour:
- Reset (sampled on a CLOCK_50 edge) forces the following at the next edge, regardless of state, including mid-run:
  - state IDLE; all outputs 0;
  - synchronizer flops, debounced level and previous debounced level to 1 (released); debounce counter 0;
  - sample timer 0; CALC_LAT delay line cleared.
- Button path:
  - 2-flop synchronizer feeds btn_s.
  - The debounce counter increments while btn_s != db and clears when equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 while btn_s != db, db takes btn_s and the counter clears.
  - press = one-cycle pulse on a db 1->0 transition. Releases generate nothing.
- FSM states:
  - IDLE: outputs low; press -> CLEAR.
  - CLEAR (exactly 1 cycle): clear_taps=1; sample timer 0; sample_count 0; -> RUN.
  - RUN: the timer counts 0..SAMPLE_DIV-1. At SAMPLE_DIV-1, shift_en=1 and the timer wraps to 0.
    - The first shift_en comes SAMPLE_DIV cycles after entering RUN.
    - press -> DRAIN. If press and timer terminal coincide, shift_en still fires, then DRAIN.
  - DRAIN: no further shift_en. If a result is outstanding, wait for its result_valid, then IDLE the next cycle; otherwise go to IDLE the next cycle. Presses in DRAIN and CLEAR are dropped.
- Result tracking:
  - result_valid = shift_en delayed by exactly CALC_LAT cycles.
  - sample_count increments in the same cycle result_valid is high.
  - At most one result is outstanding, guaranteed by SAMPLE_DIV > CALC_LAT+1.
- sample_count holds its value in IDLE for display and is cleared only by CLEAR or reset.

Optional Feature:
- Macro FIR_SEQ_AUTOSTOP_EN.
  - Defined: a shift counter (reset in CLEAR) counts shift_en pulses. The cycle that issues the SAMPLE_LIMIT-th shift_en transitions RUN -> DRAIN, so exactly SAMPLE_LIMIT results are produced. Manual press still stops early.
  - Undefined: runs until a manual press; SAMPLE_LIMIT is unused and no counter is synthesized.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, SAMPLE_DIV=8, CALC_LAT=2, CNT_W=4.
1. Reset, hold toggleBtn=1 for 50 cycles -> running, clear_taps, shift_en and result_valid stay 0; sample_count=0.
2. Glitch toggleBtn low for 2 cycles, then high -> no press; state stays IDLE.
3. Hold toggleBtn low >= 8 cycles -> one clear_taps pulse; first shift_en 8 cycles after CLEAR; result_valid 2 cycles after each shift_en; sample_count 1, 2, 3...
4. Press again mid-period after 3 results -> no more shift_en; running falls 1 cycle after the stop is taken; sample_count holds 3. Second case: stop press coinciding with a shift_en -> that shift's result_valid still appears, sample_count ends at 4, then IDLE.
5. Run 17 samples -> sample_count wraps 15 -> 0 -> 1. Assert reset mid-run -> all outputs 0 at the next edge and the FSM returns to IDLE.
6. With FIR_SEQ_AUTOSTOP_EN, SAMPLE_LIMIT=5 -> exactly 5 shift_en and 5 result_valid pulses; running drops after the 5th result_valid; sample_count=5.
